// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and shared memory port signals.
// master: the environment side (requesters and memory); slave: the arbiter.
// Handshake: a requester holds req and its payload until the arbiter
// raises gnt. gnt, mem_en and rvalid are single-cycle strobes. mem_ack
// completes the one outstanding transaction and may not arrive in the
// cycle that issued it.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_gnt;
    logic                  inst_rvalid;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic [DATA_W/8-1:0]   data_wen;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_gnt;
    logic                  data_rvalid;
    logic [DATA_W-1:0]     data_rdata;

    logic                  mem_en;
    logic [DATA_W/8-1:0]   mem_wen;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_gnt, inst_rvalid, inst_rdata,
        input  data_req, data_wen, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_gnt, inst_rvalid, inst_rdata,
        output data_req, data_wen, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data has fixed priority; fetch wins after STARVE_LIMIT consecutive losses.
// One transaction outstanding at a time; a new one may issue in the ack cycle.
// Optional performance counters are enabled with the ARB_PERF_CNT_EN macro.
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    sram_port_arbiter_if.slave    bus,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]           perf_inst_gnt,
    output logic [31:0]           perf_data_gnt,
    output logic [31:0]           perf_conflict,
`endif
    output logic [1:0]            dbg_state,
    output logic [3:0]            dbg_starve_cnt
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       wr_q, wr_d;

    logic ack_live;
    logic slot;
    logic inst_win;
    logic data_win;
    logic conflict;

    // Next state, arbitration, issue strobes and response routing.
    always_comb begin
        state_d         = state_q;
        starve_cnt_d    = starve_cnt_q;
        wr_d            = wr_q;
        ack_live        = 1'b0;
        slot            = 1'b0;
        inst_win        = 1'b0;
        data_win        = 1'b0;
        conflict        = 1'b0;
        bus.inst_gnt    = 1'b0;
        bus.inst_rvalid = 1'b0;
        bus.inst_rdata  = '0;
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b0;
        bus.data_rdata  = '0;
        bus.mem_en      = 1'b0;
        bus.mem_wen     = '0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        // Outputs are held at zero while reset is asserted.
        if (!reset) begin
            ack_live = (state_q != IDLE) && bus.mem_ack;
            if (ack_live) begin
                state_d = IDLE;
                if (state_q == BUSY_I) begin
                    bus.inst_rvalid = 1'b1;
                    bus.inst_rdata  = bus.mem_rdata;
                end else begin
                    bus.data_rvalid = 1'b1;
                    bus.data_rdata  = wr_q ? '0 : bus.mem_rdata;
                end
            end
            slot = (state_q == IDLE) || ack_live;
            if (slot) begin
                conflict = bus.inst_req && bus.data_req;
                inst_win = bus.inst_req && (!bus.data_req || starve_cnt_q >= LIMIT);
                data_win = bus.data_req && !inst_win;
                if (inst_win) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = bus.inst_addr;
                    bus.inst_gnt = 1'b1;
                    state_d      = BUSY_I;
                    starve_cnt_d = '0;
                end else if (data_win) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_wen   = bus.data_wen;
                    bus.mem_addr  = bus.data_addr;
                    bus.mem_wdata = bus.data_wdata;
                    bus.data_gnt  = 1'b1;
                    state_d       = BUSY_D;
                    wr_d          = |bus.data_wen;
                    if (bus.inst_req && starve_cnt_q < LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
        end
    end

    // State, starvation counter and write flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wr_q         <= wr_d;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_inst_q, perf_inst_d;
    logic [31:0] perf_data_q, perf_data_d;
    logic [31:0] perf_conf_q, perf_conf_d;

    // Wrapping event counters for grants and contended issue slots.
    always_comb begin
        perf_inst_d = perf_inst_q + (bus.inst_gnt ? 32'd1 : 32'd0);
        perf_data_d = perf_data_q + (bus.data_gnt ? 32'd1 : 32'd0);
        perf_conf_d = perf_conf_q + (conflict ? 32'd1 : 32'd0);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_inst_q <= '0;
            perf_data_q <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_inst_q <= perf_inst_d;
            perf_data_q <= perf_data_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_inst_gnt = perf_inst_q;
    assign perf_data_gnt = perf_data_q;
    assign perf_conflict = perf_conf_q;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed cycle table, reset sequences and
// randomized traffic against a transaction-level reference model.
module tb_sram_port_arbiter;
  localparam int LIMIT = 4;

  logic clock;
  logic reset;
  logic [1:0] dbg_state;
  logic [3:0] dbg_starve_cnt;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_gnt, perf_data_gnt, perf_conflict;
`endif

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
`ifdef ARB_PERF_CNT_EN
    .perf_inst_gnt  (perf_inst_gnt),
    .perf_data_gnt  (perf_data_gnt),
    .perf_conflict  (perf_conflict),
`endif
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic [3:0]  wen;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
  } in_t;

  typedef struct packed {
    logic        ign;
    logic        dgn;
    logic        men;
    logic [3:0]  mwen;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        irv;
    logic [31:0] ird;
    logic        drv;
    logic [31:0] drd;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: outstanding transactions as {is_data, is_write}
  logic [1:0] exp_q[$];
  int losses = 0;
  int m_pi = 0, m_pd = 0, m_pc = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input out_t a, input out_t e);
    cmp({tag, ".inst_gnt"},    32'(a.ign),  32'(e.ign));
    cmp({tag, ".data_gnt"},    32'(a.dgn),  32'(e.dgn));
    cmp({tag, ".mem_en"},      32'(a.men),  32'(e.men));
    cmp({tag, ".mem_wen"},     32'(a.mwen), 32'(e.mwen));
    cmp({tag, ".mem_addr"},    a.maddr,     e.maddr);
    cmp({tag, ".mem_wdata"},   a.mwdata,    e.mwdata);
    cmp({tag, ".inst_rvalid"}, 32'(a.irv),  32'(e.irv));
    cmp({tag, ".inst_rdata"},  a.ird,       e.ird);
    cmp({tag, ".data_rvalid"}, 32'(a.drv),  32'(e.drv));
    cmp({tag, ".data_rdata"},  a.drd,       e.drd);
  endtask

  // driver: apply one cycle of inputs, sample outputs at negedge, advance model
  task automatic run_cycle(input in_t i, input bit chk_model, input string tag, output out_t a);
    out_t e;
    logic [1:0] t;
    bit busy, slot, iw, dw;
    reset          = i.rst;
    bus.inst_req   = i.ireq;
    bus.inst_addr  = i.iaddr;
    bus.data_req   = i.dreq;
    bus.data_wen   = i.wen;
    bus.data_addr  = i.daddr;
    bus.data_wdata = i.wdata;
    bus.mem_ack    = i.ack;
    bus.mem_rdata  = i.rdata;
    @(negedge clock);
    a.ign = bus.inst_gnt;   a.dgn = bus.data_gnt;  a.men = bus.mem_en;
    a.mwen = bus.mem_wen;   a.maddr = bus.mem_addr; a.mwdata = bus.mem_wdata;
    a.irv = bus.inst_rvalid; a.ird = bus.inst_rdata;
    a.drv = bus.data_rvalid; a.drd = bus.data_rdata;
    e = '0;
    if (i.rst) begin
      exp_q.delete();
      losses = 0;
      m_pi = 0; m_pd = 0; m_pc = 0;
    end else begin
      busy = (exp_q.size() > 0);
      if (i.ack && busy) begin
        t = exp_q.pop_front();
        if (t[1]) begin
          e.drv = 1'b1;
          e.drd = t[0] ? 32'h0 : i.rdata;
        end else begin
          e.irv = 1'b1;
          e.ird = i.rdata;
        end
      end
      slot = !busy || i.ack;
      if (slot) begin
        if (i.ireq && i.dreq) m_pc++;
        iw = i.ireq && (!i.dreq || losses >= LIMIT);
        dw = i.dreq && !iw;
        if (iw) begin
          e.ign = 1'b1; e.men = 1'b1; e.maddr = i.iaddr;
          exp_q.push_back(2'b00);
          losses = 0;
          m_pi++;
        end else if (dw) begin
          e.dgn = 1'b1; e.men = 1'b1; e.mwen = i.wen;
          e.maddr = i.daddr; e.mwdata = i.wdata;
          exp_q.push_back({1'b1, |i.wen});
          if (i.ireq && losses < LIMIT) losses++;
          m_pd++;
        end
      end
    end
    if (chk_model) cmp_out(tag, a, e);
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] IA = 32'hBFC00000;
  localparam logic [31:0] DA = 32'h80001000;
  localparam logic [31:0] WD = 32'hDEADBEEF;

  function automatic vec_t v(input logic ireq, input logic dreq, input logic [3:0] wen,
                             input logic ack, input logic [31:0] rdata,
                             input logic e_ign, input logic e_dgn, input logic [3:0] e_mwen,
                             input logic e_irv, input logic e_drv, input logic [31:0] e_rd);
    vec_t r;
    r.i = '{rst: 1'b0, ireq: ireq, dreq: dreq, wen: wen, ack: ack, rdata: rdata,
            iaddr: IA, daddr: DA, wdata: WD};
    r.e = '0;
    r.e.ign    = e_ign;
    r.e.dgn    = e_dgn;
    r.e.men    = e_ign | e_dgn;
    r.e.mwen   = e_mwen;
    r.e.maddr  = e_ign ? IA : (e_dgn ? DA : 32'h0);
    r.e.mwdata = e_dgn ? WD : 32'h0;
    r.e.irv    = e_irv;
    r.e.ird    = e_irv ? e_rd : 32'h0;
    r.e.drv    = e_drv;
    r.e.drd    = e_drv ? e_rd : 32'h0;
    return r;
  endfunction

  vec_t tbl[21];
  in_t  ri;
  out_t ra;

  initial begin
    // single fetch, two-cycle latency
    tbl[0]  = v(1, 0, 4'h0, 0, 32'h0,        1, 0, 4'h0, 0, 0, 32'h0);
    tbl[1]  = v(0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 0, 0, 32'h0);
    tbl[2]  = v(0, 0, 4'h0, 1, 32'h3C1D0001, 0, 0, 4'h0, 1, 0, 32'h3C1D0001);
    tbl[3]  = v(0, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 0, 0, 32'h0);
    // write completion returns zero data
    tbl[4]  = v(0, 1, 4'hF, 0, 32'h0,        0, 1, 4'hF, 0, 0, 32'h0);
    tbl[5]  = v(0, 0, 4'h0, 1, 32'h12345678, 0, 0, 4'h0, 0, 1, 32'h0);
    // data read
    tbl[6]  = v(0, 1, 4'h0, 0, 32'h0,        0, 1, 4'h0, 0, 0, 32'h0);
    tbl[7]  = v(0, 0, 4'h0, 1, 32'hA5A5A5A5, 0, 0, 4'h0, 0, 1, 32'hA5A5A5A5);
    // back-to-back fetch in the ack cycle
    tbl[8]  = v(1, 0, 4'h0, 0, 32'h0,        1, 0, 4'h0, 0, 0, 32'h0);
    tbl[9]  = v(1, 0, 4'h0, 1, 32'h11111111, 1, 0, 4'h0, 1, 0, 32'h11111111);
    tbl[10] = v(0, 0, 4'h0, 1, 32'h22222222, 0, 0, 4'h0, 1, 0, 32'h22222222);
    // ack while idle is ignored
    tbl[11] = v(0, 0, 4'h0, 1, 32'h33333333, 0, 0, 4'h0, 0, 0, 32'h0);
    tbl[12] = v(1, 0, 4'h0, 0, 32'h0,        1, 0, 4'h0, 0, 0, 32'h0);
    tbl[13] = v(0, 0, 4'h0, 1, 32'h44444444, 0, 0, 4'h0, 1, 0, 32'h44444444);
    // both requesting: D,D,D,D,I,D
    tbl[14] = v(1, 1, 4'h0, 0, 32'h0,        0, 1, 4'h0, 0, 0, 32'h0);
    tbl[15] = v(1, 1, 4'h0, 1, 32'h101,      0, 1, 4'h0, 0, 1, 32'h101);
    tbl[16] = v(1, 1, 4'h0, 1, 32'h102,      0, 1, 4'h0, 0, 1, 32'h102);
    tbl[17] = v(1, 1, 4'h0, 1, 32'h103,      0, 1, 4'h0, 0, 1, 32'h103);
    tbl[18] = v(1, 1, 4'h0, 1, 32'h104,      1, 0, 4'h0, 0, 1, 32'h104);
    tbl[19] = v(1, 1, 4'h0, 1, 32'h105,      0, 1, 4'h0, 1, 0, 32'h105);
    tbl[20] = v(0, 0, 4'h0, 1, 32'h106,      0, 0, 4'h0, 0, 1, 32'h106);

    // reset with requests pending: all outputs zero
    ri = tbl[0].i;
    ri.rst = 1'b1; ri.dreq = 1'b1; ri.ack = 1'b1; ri.rdata = 32'h5555AAAA;
    @(posedge clock); #1;
    run_cycle(ri, 1'b0, "rst0", ra);
    cmp_out("rst0", ra, '0);
    run_cycle(ri, 1'b0, "rst1", ra);
    cmp("rst.state", 32'(dbg_state), 32'd0);
    cmp("rst.starve", 32'(dbg_starve_cnt), 32'd0);

    // directed cycle table
    for (int k = 0; k < 21; k++) begin
      run_cycle(tbl[k].i, 1'b0, "", ra);
      cmp_out($sformatf("tbl%0d", k), ra, tbl[k].e);
      if (k == 3 || k == 11) cmp($sformatf("tbl%0d.state_idle", k), 32'(dbg_state), 32'd0);
      if (k == 17) cmp("tbl17.starve_sat", 32'(dbg_starve_cnt), 32'(LIMIT));
      if (k == 18) cmp("tbl18.starve_clr", 32'(dbg_starve_cnt), 32'd0);
    end

    // reset during an outstanding data access drops its response
    ri = tbl[6].i;
    run_cycle(ri, 1'b0, "", ra);
    cmp("mid.data_gnt", 32'(ra.dgn), 32'd1);
    ri = tbl[0].i; ri.rst = 1'b1;
    run_cycle(ri, 1'b0, "", ra);
    cmp_out("mid_rst", ra, '0);
    ri = tbl[1].i; ri.ack = 1'b1; ri.rdata = 32'h77777777;
    run_cycle(ri, 1'b0, "", ra);
    cmp_out("mid_ack", ra, '0);
    cmp("mid.state", 32'(dbg_state), 32'd0);

    // randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      ri.rst   = ($urandom_range(0, 79) == 0);
      ri.ireq  = $urandom_range(0, 1);
      ri.dreq  = $urandom_range(0, 1);
      ri.wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ri.ack   = (exp_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      ri.rdata = $urandom;
      ri.iaddr = $urandom;
      ri.daddr = $urandom;
      ri.wdata = $urandom;
      run_cycle(ri, 1'b1, $sformatf("rnd%0d", c), ra);
    end

`ifdef ARB_PERF_CNT_EN
    cmp("perf_inst_gnt", perf_inst_gnt, 32'(m_pi));
    cmp("perf_data_gnt", perf_data_gnt, 32'(m_pd));
    cmp("perf_conflict", perf_conflict, 32'(m_pc));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the core's instruction-fetch requester and its data requester.
- Used when the core is wired to a single-ported memory or a single bus bridge instead of separate inst/data SRAMs.
- Arbitration is fixed data-priority with a starvation guard for fetch. Exactly one transaction is outstanding at a time.
- Variable memory latency: each response is signalled by mem_ack.

Parameters:
- ADDR_W, 32, address width of the requester and memory ports.
- DATA_W, 32, data width; the byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive lost arbitrations by inst after which inst wins. Legal range 1..15.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held with inst_addr until inst_gnt.
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  fetch request issued to memory this cycle.
- inst_rvalid  out  1  fetch response valid (one-cycle pulse).
- inst_rdata  out  DATA_W  fetch read data.
- data_req  in  1  data request; held with wen/addr/wdata until data_gnt.
- data_wen  in  DATA_W/8  byte write enables; 0 means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_gnt  out  1  data request issued this cycle.
- data_rvalid  out  1  data response valid (read or write completion).
- data_rdata  out  DATA_W  read data; 0 on write completion.
- mem_en  out  1  issue strobe to memory (one cycle per transaction).
- mem_wen  out  DATA_W/8  byte enables of the issued transaction.
- mem_addr  out  ADDR_W  address of the issued transaction.
- mem_wdata  out  DATA_W  write data of the issued transaction.
- mem_ack  in  1  memory response for the outstanding transaction.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.

Behaviour:
- Reset values: state=IDLE, starve_cnt=0, owner=NONE. All outputs 0: gnt, rvalid, mem_en, mem_wen, mem_addr, mem_wdata, rdata.
- States:
  - IDLE: no outstanding transaction.
  - BUSY_I: fetch outstanding.
  - BUSY_D: data access outstanding.
- Issue slot exists in IDLE, or in BUSY_* in the same cycle mem_ack=1 (back-to-back issue). No issue otherwise.
- Winner in an issue slot:
  - Only one req asserted: that requester wins.
  - Both asserted: data wins, unless starve_cnt >= STARVE_LIMIT, then inst wins.
- Issue:
  - mem_en=1 combinationally, with mem_wen/addr/wdata copied from the winner (inst issues mem_wen=0).
  - The winner's gnt=1 in the same cycle.
  - Next state is BUSY_I or BUSY_D.
  - When not issuing, mem_en=0 and mem_wen=0.
- starve_cnt (register):
  - Increments, saturating at STARVE_LIMIT, in any issue slot where inst_req=1 but data wins.
  - Clears to 0 when inst wins.
  - Holds otherwise.
- Response:
  - In BUSY_I with mem_ack: inst_rvalid=1, inst_rdata=mem_rdata, combinational, same cycle.
  - In BUSY_D with mem_ack: data_rvalid=1; data_rdata=mem_rdata for a read, 0 for a write (write flag latched at issue).
  - rvalid/rdata are 0 when no response.
- After mem_ack with no issue: next state IDLE.
- mem_ack while IDLE is ignored. No response is produced and no state changes.
- A requester may deassert req before gnt. The arbiter samples req only in issue slots; there is no request latching.
- Minimum latency: issue in cycle N; response no earlier than N+1 (mem_ack in the issue cycle is not allowed for that same transaction).
- Reset mid-transaction forces IDLE and discards the outstanding response. The memory must share this reset.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_inst_gnt (32), perf_data_gnt (32), perf_conflict (32).
  - perf_inst_gnt and perf_data_gnt count grants per requester.
  - perf_conflict counts issue slots with both req asserted.
  - All wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Single fetch: inst_req=1, addr=0xBFC00000; mem_ack two cycles later with rdata=0x3C1D0001 -> inst_gnt and mem_en in the issue cycle, mem_addr=0xBFC00000, mem_wen=0; inst_rvalid=1 with inst_rdata=0x3C1D0001 on the ack cycle; state returns to IDLE.
- Simultaneous requests, STARVE_LIMIT=4: both req held continuously, 1-cycle ack -> data granted 4 times, then inst; starve_cnt returns to 0; pattern repeats D,D,D,D,I.
- Write completion: data_wen=0xF, addr=0x80001000, wdata=0xDEADBEEF -> mem_wen=0xF, mem_wdata=0xDEADBEEF; on ack data_rvalid=1 with data_rdata=0.
- Back-to-back: ack arrives while inst_req=1 -> new issue in the same cycle as inst_rvalid; no idle bubble.
- Reset mid-operation: reset asserted during BUSY_D; mem_ack arrives after reset releases -> no data_rvalid; all outputs 0 during reset.
- ARB_PERF_CNT_EN defined: 3 inst grants, 5 data grants, 2 conflict slots -> counters read 3, 5, 2.
